// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if
// Bundles everything the SRAM arbiter exchanges with the outside world:
//   - CPU request port   : cpuReq/cpuWe/cpuAddr/cpuWData in, cpuAck/cpuRData out
//   - DMA request port   : dmaReq/dmaWe/dmaAddr/dmaWData in, dmaAck/dmaRData out
//   - SRAM chip side     : memAddr/memWData/memDataOE/memNotCS/memNotOE/memNotWE out,
//                          memRData in
//   - Status             : busy (access in progress), grant (owner of current/last access)
// The slave modport is the arbiter's view; the master modport is the view of
// the environment (requesters plus the SRAM device).
interface sram_arbiter_if;
  logic        cpuReq;
  logic        cpuWe;
  logic [15:0] cpuAddr;
  logic [15:0] cpuWData;
  logic        cpuAck;
  logic [15:0] cpuRData;

  logic        dmaReq;
  logic        dmaWe;
  logic [15:0] dmaAddr;
  logic [15:0] dmaWData;
  logic        dmaAck;
  logic [15:0] dmaRData;

  logic [15:0] memAddr;
  logic [15:0] memWData;
  logic        memDataOE;
  logic [15:0] memRData;
  logic        memNotCS;
  logic        memNotOE;
  logic        memNotWE;

  logic        busy;
  logic        grant;

  modport slave (
    input  cpuReq, cpuWe, cpuAddr, cpuWData,
    input  dmaReq, dmaWe, dmaAddr, dmaWData,
    input  memRData,
    output cpuAck, cpuRData, dmaAck, dmaRData,
    output memAddr, memWData, memDataOE, memNotCS, memNotOE, memNotWE,
    output busy, grant
  );

  modport master (
    output cpuReq, cpuWe, cpuAddr, cpuWData,
    output dmaReq, dmaWe, dmaAddr, dmaWData,
    output memRData,
    input  cpuAck, cpuRData, dmaAck, dmaRData,
    input  memAddr, memWData, memDataOE, memNotCS, memNotOE, memNotWE,
    input  busy, grant
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter
// Shares one asynchronous SRAM between the CPU port and the DMA port. Each
// granted request runs a fixed strobe sequence SETUP -> ACCESS (WAIT_CYCLES
// cycles) -> DONE, then a one-cycle ack is returned to the winner together with
// its registered read word. Contention is resolved round-robin: when both ports
// request in IDLE, the port that did not win last time is served.
// Ports:
//   clock  - system clock, all state changes on the rising edge
//   reset  - synchronous, active-high
//   bus    - sram_arbiter_if.slave: both request ports, SRAM pins, busy/grant
// Parameter:
//   WAIT_CYCLES - cycles the OE/WE strobe is held in ACCESS (legal 1..15)

// Protocol properties of the SRAM pins, kept apart from the datapath.
module sram_arbiter_chk (
  input logic clock,
  input logic reset,
  input logic memNotCS,
  input logic memNotOE,
  input logic memNotWE,
  input logic memDataOE,
  input logic cpuAck,
  input logic dmaAck
);
  // Read and write strobes are mutually exclusive.
  noOeWithWe: assert property (@(posedge clock) disable iff (reset)
    !(!memNotOE && !memNotWE));

  // The arbiter must not drive the data bus while the SRAM drives it.
  noBusFight: assert property (@(posedge clock) disable iff (reset)
    !(!memNotOE && memDataOE));

  // A strobe is only meaningful with chip select active.
  strobeNeedsCs: assert property (@(posedge clock) disable iff (reset)
    (!memNotOE || !memNotWE) |-> !memNotCS);

  // Only one port is ever acknowledged in a cycle.
  singleAck: assert property (@(posedge clock) disable iff (reset)
    !(cpuAck && dmaAck));
endmodule

module sram_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input logic          clock,
  input logic          reset,
  sram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10,
    DONE   = 2'b11
  } state_t;

  // ACCESS counts cnt down to zero, so loading WAIT_CYCLES-1 yields
  // exactly WAIT_CYCLES cycles in ACCESS.
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic        lastGrant_r;
  logic        grant_r;
  logic        accWe_r;
  logic [15:0] memAddr_r;
  logic [15:0] memWData_r;
  logic        memDataOE_r;
  logic        memNotCS_r;
  logic        memNotOE_r;
  logic        memNotWE_r;
  logic        cpuAck_r;
  logic        dmaAck_r;
  logic [15:0] cpuRData_r;
  logic [15:0] dmaRData_r;
  logic        busy_r;

  logic        anyReq_s;
  logic        winner_s;
  logic        winWe_s;
  logic [15:0] winAddr_s;
  logic [15:0] winWData_s;

  // Round-robin winner selection and mux of the winner's request fields.
  always_comb begin
    anyReq_s   = bus.cpuReq | bus.dmaReq;
    winner_s   = 1'b0;
    winWe_s    = bus.cpuWe;
    winAddr_s  = bus.cpuAddr;
    winWData_s = bus.cpuWData;
    if (bus.cpuReq && bus.dmaReq) begin
      winner_s = ~lastGrant_r;
    end else if (bus.dmaReq) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
    if (winner_s) begin
      winWe_s    = bus.dmaWe;
      winAddr_s  = bus.dmaAddr;
      winWData_s = bus.dmaWData;
    end else begin
      winWe_s    = bus.cpuWe;
      winAddr_s  = bus.cpuAddr;
      winWData_s = bus.cpuWData;
    end
  end

  // Access sequencer: state, counter, latched request and all registered outputs.
  // Each branch assigns the pin values for the state being entered, so the
  // strobes seen in a state come straight from flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      lastGrant_r <= 1'b1;
      grant_r     <= 1'b0;
      accWe_r     <= 1'b0;
      memAddr_r   <= 16'h0000;
      memWData_r  <= 16'h0000;
      memDataOE_r <= 1'b0;
      memNotCS_r  <= 1'b1;
      memNotOE_r  <= 1'b1;
      memNotWE_r  <= 1'b1;
      cpuAck_r    <= 1'b0;
      dmaAck_r    <= 1'b0;
      cpuRData_r  <= 16'h0000;
      dmaRData_r  <= 16'h0000;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          cpuAck_r <= 1'b0;
          dmaAck_r <= 1'b0;
          if (anyReq_s) begin
            grant_r     <= winner_s;
            lastGrant_r <= winner_s;
            accWe_r     <= winWe_s;
            memAddr_r   <= winAddr_s;
            memWData_r  <= winWData_s;
            // Entering SETUP: chip select on, OE for reads or data drive for
            // writes, WE held off for address setup.
            memNotCS_r  <= 1'b0;
            memNotOE_r  <= winWe_s;
            memNotWE_r  <= 1'b1;
            memDataOE_r <= winWe_s;
            busy_r      <= 1'b1;
            state_r     <= SETUP;
          end else begin
            memNotCS_r  <= 1'b1;
            memNotOE_r  <= 1'b1;
            memNotWE_r  <= 1'b1;
            memDataOE_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end

        SETUP: begin
          cnt_r       <= CNT_LOAD;
          memNotCS_r  <= 1'b0;
          memNotOE_r  <= accWe_r;
          memNotWE_r  <= ~accWe_r;
          memDataOE_r <= accWe_r;
          state_r     <= ACCESS;
        end

        ACCESS: begin
          if (cnt_r == 4'd0) begin
            // Final ACCESS edge: release strobes, keep write data driven for
            // hold time, raise the winner's ack and capture read data.
            memNotCS_r  <= 1'b1;
            memNotOE_r  <= 1'b1;
            memNotWE_r  <= 1'b1;
            memDataOE_r <= accWe_r;
            if (grant_r) begin
              dmaAck_r <= 1'b1;
              if (!accWe_r) begin
                dmaRData_r <= bus.memRData;
              end else begin
                dmaRData_r <= dmaRData_r;
              end
            end else begin
              cpuAck_r <= 1'b1;
              if (!accWe_r) begin
                cpuRData_r <= bus.memRData;
              end else begin
                cpuRData_r <= cpuRData_r;
              end
            end
            state_r <= DONE;
          end else begin
            cnt_r   <= cnt_r - 4'd1;
            state_r <= ACCESS;
          end
        end

        DONE: begin
          // Always return to IDLE so a req still held during ack is not
          // re-granted on the ack cycle itself.
          cpuAck_r    <= 1'b0;
          dmaAck_r    <= 1'b0;
          memNotCS_r  <= 1'b1;
          memNotOE_r  <= 1'b1;
          memNotWE_r  <= 1'b1;
          memDataOE_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end

        default: begin
          cpuAck_r    <= 1'b0;
          dmaAck_r    <= 1'b0;
          memNotCS_r  <= 1'b1;
          memNotOE_r  <= 1'b1;
          memNotWE_r  <= 1'b1;
          memDataOE_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.memAddr   = memAddr_r;
  assign bus.memWData  = memWData_r;
  assign bus.memDataOE = memDataOE_r;
  assign bus.memNotCS  = memNotCS_r;
  assign bus.memNotOE  = memNotOE_r;
  assign bus.memNotWE  = memNotWE_r;
  assign bus.cpuAck    = cpuAck_r;
  assign bus.dmaAck    = dmaAck_r;
  assign bus.cpuRData  = cpuRData_r;
  assign bus.dmaRData  = dmaRData_r;
  assign bus.busy      = busy_r;
  assign bus.grant     = grant_r;

  sram_arbiter_chk chk (
    .clock     (clock),
    .reset     (reset),
    .memNotCS  (memNotCS_r),
    .memNotOE  (memNotOE_r),
    .memNotWE  (memNotWE_r),
    .memDataOE (memDataOE_r),
    .cpuAck    (cpuAck_r),
    .dmaAck    (dmaAck_r)
  );

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
// Drives both request ports of sram_arbiter, models the SRAM chip, and checks
// every acknowledged access against a reference memory and the strobe timing
// rules (SETUP + WAIT_CYCLES ACCESS + DONE).
module tb_sram_arbiter;
  localparam int W = 3;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } txn_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  sram_arbiter_if bus ();

  sram_arbiter #(.WAIT_CYCLES(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic        req   [2];
  logic        we    [2];
  logic [15:0] addr  [2];
  logic [15:0] wdata [2];

  assign bus.cpuReq   = req[0];
  assign bus.cpuWe    = we[0];
  assign bus.cpuAddr  = addr[0];
  assign bus.cpuWData = wdata[0];
  assign bus.dmaReq   = req[1];
  assign bus.dmaWe    = we[1];
  assign bus.dmaAddr  = addr[1];
  assign bus.dmaWData = wdata[1];

  // SRAM device model with a preload port used during reset.
  logic [15:0] sram   [0:65535];
  logic [15:0] refMem [0:65535];
  logic        pre;
  logic [15:0] preA, preD;

  always @(posedge clock) begin
    if (pre)
      sram[preA] <= preD;
    else if (!bus.memNotCS && !bus.memNotWE && bus.memDataOE)
      sram[bus.memAddr] <= bus.memWData;
  end
  assign bus.memRData = (!bus.memNotCS && !bus.memNotOE) ? sram[bus.memAddr] : 16'hDEAD;

  logic [15:0] addrSet [8] = '{16'h0000, 16'h0001, 16'h0010, 16'h00FF,
                               16'h8000, 16'h1234, 16'hAAAA, 16'hFFFF};

  int total  = 0;
  int passed = 0;
  int cyc    = 0;
  always @(posedge clock) cyc <= cyc + 1;

  txn_t q0[$];
  txn_t q1[$];
  int   ackPort[$];
  int   ackCycle[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual %0h, required %0h", name, act, exp);
  endtask

  function automatic logic ackOf(input int p);
    return (p == 0) ? bus.cpuAck : bus.dmaAck;
  endfunction

  function automatic logic [15:0] rdOf(input int p);
    return (p == 0) ? bus.cpuRData : bus.dmaRData;
  endfunction

  // Issue one request, wait for its ack, then step past the ack cycle.
  // Returns with req still high when keep is set so the caller can chain.
  task automatic access(input int p, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input bit keep, output int lat);
    txn_t t;
    int n;
    t.we = w; t.addr = a; t.data = d;
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
    if (p == 0) q0.push_back(t); else q1.push_back(t);
    n = 0;
    do begin
      @(posedge clock); #1; n++;
    end while (!ackOf(p) && n < 200);
    if (!ackOf(p)) check($sformatf("ack timeout port %0d", p), 32'(n), 32'd200 + 32'd1);
    lat = n;
    @(posedge clock); #1;
    if (!keep) req[p] = 1'b0;
  endtask

  // Monitor: per-access strobe accounting and scoreboard compare on every ack.
  logic [15:0] lastRd [2];
  bit          inAcc;
  int          nCyc, nWeLow, nOeLow, nCsLow, nDoe;
  logic [15:0] a0, d0;
  bit          stable;

  initial begin
    txn_t t;
    int p;
    logic [15:0] expRd;
    inAcc = 0;
    lastRd[0] = 16'h0; lastRd[1] = 16'h0;
    forever begin
      @(negedge clock);
      if (reset) begin
        inAcc = 0;
        lastRd[0] = 16'h0; lastRd[1] = 16'h0;
      end else begin
        if (!inAcc && bus.busy) begin
          inAcc = 1; nCyc = 0; nWeLow = 0; nOeLow = 0; nCsLow = 0; nDoe = 0;
          a0 = bus.memAddr; d0 = bus.memWData; stable = 1;
        end
        if (inAcc) begin
          nCyc++;
          if (!bus.memNotWE) nWeLow++;
          if (!bus.memNotOE) nOeLow++;
          if (!bus.memNotCS) nCsLow++;
          if (bus.memDataOE) nDoe++;
          if (bus.memAddr != a0 || bus.memWData != d0) stable = 0;
        end
        if (bus.cpuAck || bus.dmaAck) begin
          check("one ack at a time", {31'd0, bus.cpuAck & bus.dmaAck}, 32'd0);
          p = bus.dmaAck ? 1 : 0;
          check($sformatf("port %0d ack has pending request", p),
                (p == 0) ? 32'(q0.size() > 0) : 32'(q1.size() > 0), 32'd1);
          if ((p == 0 && q0.size() > 0) || (p == 1 && q1.size() > 0)) begin
            t = (p == 0) ? q0.pop_front() : q1.pop_front();
            check("grant", {31'd0, bus.grant}, 32'(p));
            check("access cycles", 32'(nCyc), 32'(W + 2));
            check("memAddr", {16'd0, a0}, {16'd0, t.addr});
            check("addr/data stable", {31'd0, stable}, 32'd1);
            check("cs low cycles", 32'(nCsLow), 32'(W + 1));
            if (t.we) begin
              check("memWData", {16'd0, d0}, {16'd0, t.data});
              check("we low cycles", 32'(nWeLow), 32'(W));
              check("dataOE cycles", 32'(nDoe), 32'(W + 2));
              check("oe low on write", 32'(nOeLow), 32'd0);
              refMem[t.addr] = t.data;
              check("rdata kept on write", {16'd0, rdOf(p)}, {16'd0, lastRd[p]});
            end else begin
              expRd = refMem[t.addr];
              check("oe low cycles", 32'(nOeLow), 32'(W + 1));
              check("we low on read", 32'(nWeLow), 32'd0);
              check("dataOE on read", 32'(nDoe), 32'd0);
              check($sformatf("port %0d read data", p), {16'd0, rdOf(p)}, {16'd0, expRd});
              lastRd[p] = expRd;
            end
            check("other port rdata kept", {16'd0, rdOf(1 - p)}, {16'd0, lastRd[1 - p]});
          end
          ackPort.push_back(p);
          ackCycle.push_back(cyc);
          inAcc = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  initial begin
    int lat;
    int base;
    logic [15:0] v;
    reset = 1'b1; pre = 1'b0; preA = 16'h0; preD = 16'h0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = 16'h0; wdata[i] = 16'h0;
    end
    repeat (2) begin @(posedge clock); #1; end

    check("reset memNotCS", {31'd0, bus.memNotCS}, 32'd1);
    check("reset memNotOE", {31'd0, bus.memNotOE}, 32'd1);
    check("reset memNotWE", {31'd0, bus.memNotWE}, 32'd1);
    check("reset memDataOE", {31'd0, bus.memDataOE}, 32'd0);
    check("reset acks", {30'd0, bus.cpuAck, bus.dmaAck}, 32'd0);
    check("reset rdata", {bus.cpuRData, bus.dmaRData}, 32'd0);
    check("reset memAddr/memWData", {bus.memAddr, bus.memWData}, 32'd0);
    check("reset busy/grant", {30'd0, bus.busy, bus.grant}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      v = (addrSet[i] == 16'hFFFF) ? 16'h1234 : (16'($urandom) | 16'h0001);
      preA = addrSet[i]; preD = v; refMem[addrSet[i]] = v; pre = 1'b1;
      @(posedge clock); #1;
    end
    pre = 1'b0;

    // Both ports request straight out of reset and keep requesting.
    base = ackPort.size();
    @(posedge clock); #1;
    reset = 1'b0;
    fork
      begin : cpuSide
        int l0;
        for (int k = 0; k < 4; k++) access(0, 1'b0, addrSet[1], 16'h0, (k < 3), l0);
      end
      begin : dmaSide
        int l1;
        for (int k = 0; k < 4; k++) access(1, 1'b0, addrSet[3], 16'h0, (k < 3), l1);
      end
    join
    check("contention ack count", 32'(ackPort.size() - base), 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (base + k < ackPort.size()) begin
        check($sformatf("contention order %0d", k), 32'(ackPort[base + k]), 32'(k % 2));
        if (k > 0)
          check($sformatf("contention spacing %0d", k),
                32'(ackCycle[base + k] - ackCycle[base + k - 1]), 32'(W + 3));
      end
    end

    // Reset in the middle of a CPU write aborts it.
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0010; wdata[0] = 16'h5555;
    repeat (3) begin @(posedge clock); #1; end
    check("write in progress before reset", {30'd0, bus.memNotWE, bus.busy}, 32'd1);
    reset = 1'b1; req[0] = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    reset = 1'b0;
    check("abort strobes", {29'd0, bus.memNotWE, bus.memNotCS, bus.memDataOE}, 32'd6);
    check("abort busy/ack", {30'd0, bus.busy, bus.cpuAck}, 32'd0);
    check("abort cpuRData", {16'd0, bus.cpuRData}, 32'd0);
    @(posedge clock); #1;
    check("no ack after abort", {30'd0, bus.cpuAck, bus.dmaAck}, 32'd0);

    // Directed write / read back and DMA read of the top address.
    access(0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, lat);
    check("write latency", 32'(lat), 32'(W + 2));
    access(0, 1'b0, 16'h0010, 16'h0000, 1'b0, lat);
    check("read latency", 32'(lat), 32'(W + 2));
    check("cpu readback", {16'd0, bus.cpuRData}, 32'h0000BEEF);
    access(1, 1'b0, 16'hFFFF, 16'h0000, 1'b0, lat);
    check("dma read 0xFFFF", {16'd0, bus.dmaRData}, 32'h00001234);
    check("cpuRData unchanged by dma", {16'd0, bus.cpuRData}, 32'h0000BEEF);

    // CPU chains two requests; DMA arrives mid-access and is served between.
    base = ackPort.size();
    fork
      begin : cpuChain
        int l2;
        access(0, 1'b1, 16'h00FF, 16'($urandom), 1'b1, l2);
        access(0, 1'b0, 16'h8000, 16'h0000, 1'b0, l2);
      end
      begin : dmaLate
        int l3;
        repeat (3) begin @(posedge clock); #1; end
        access(1, 1'b0, 16'hAAAA, 16'h0000, 1'b0, l3);
      end
    join
    check("chain ack count", 32'(ackPort.size() - base), 32'd3);
    for (int k = 0; k < 3; k++)
      if (base + k < ackPort.size())
        check($sformatf("chain order %0d", k), 32'(ackPort[base + k]), (k == 1) ? 32'd1 : 32'd0);

    // Random traffic on both ports.
    fork
      begin : cpuRand
        int l4, g4;
        bit k4;
        for (int k = 0; k < 40; k++) begin
          g4 = $urandom_range(0, 3);
          k4 = (g4 == 0) && (k < 39);
          access(0, 1'($urandom_range(0, 1)), addrSet[$urandom_range(0, 7)], 16'($urandom), k4, l4);
          if (!k4) repeat (g4) begin @(posedge clock); #1; end
        end
      end
      begin : dmaRand
        int l5, g5;
        bit k5;
        for (int k = 0; k < 40; k++) begin
          g5 = $urandom_range(0, 3);
          k5 = (g5 == 0) && (k < 39);
          access(1, 1'($urandom_range(0, 1)), addrSet[$urandom_range(0, 7)], 16'($urandom), k5, l5);
          if (!k5) repeat (g5) begin @(posedge clock); #1; end
        end
      end
    join

    repeat (4) begin @(posedge clock); #1; end
    check("cpu queue drained", 32'(q0.size()), 32'd0);
    check("dma queue drained", 32'(q1.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single asynchronous SRAM between two requesters: the CPU memory port and a DMA/peripheral port. It runs a fixed-length, strobe-sequenced SRAM cycle per request. On contention it arbitrates round-robin, and it returns a one-cycle acknowledge plus a registered read word to the winner. It replaces direct microcode control of the SRAM chip-select, output-enable and write-enable lines.

## Interface
- WAIT_CYCLES, 1, cycles `memNotOE`/`memNotWE` held active in ACCESS (legal 1..15)
- clock  in  1  system clock, all state changes on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clock
- cpuReq  in  1  CPU access request; held with cpuWe/cpuAddr/cpuWData until cpuAck
- cpuWe  in  1  1 = write, 0 = read
- cpuAddr  in  16  word address
- cpuWData  in  16  write data
- cpuAck  out  1  one-cycle completion pulse
- cpuRData  out  16  last word read for CPU
- dmaReq, dmaWe, dmaAddr, dmaWData, dmaAck, dmaRData: same as cpu* for the DMA port
- memAddr  out  16  SRAM address
- memWData  out  16  SRAM write data
- memDataOE  out  1  1 = drive memWData onto SRAM data bus
- memRData  in  16  SRAM read data
- memNotCS, memNotOE, memNotWE  out  1  SRAM strobes, active-low
- busy  out  1  1 when state != IDLE
- grant  out  1  owner of current/last access: 0 = CPU, 1 = DMA

## Operation
- States: IDLE, SETUP, ACCESS, DONE. A 4-bit wait counter `cnt` and a `lastGrant` bit carry the rest of the state.
- IDLE, all strobes high, memDataOE = 0. If any req is high at the edge:
  - choose the winner (only one req high: that port; both high: port != lastGrant);
  - latch its addr, wdata and we into the access registers; set grant and lastGrant to the winner;
  - go to SETUP.
- SETUP (1 cycle): memNotCS = 0. Read: memNotOE = 0. Write: memDataOE = 1. memNotWE stays 1 (address setup). Load cnt = WAIT_CYCLES-1 and go to ACCESS.
- ACCESS (WAIT_CYCLES cycles): memNotCS = 0. Read: memNotOE = 0. Write: memNotWE = 0, memDataOE = 1. Decrement cnt; when cnt == 0, go to DONE. On that final edge of a read, capture memRData into the winner's RData register.
- DONE (1 cycle): all strobes high. Write: memDataOE stays 1 (hold time). Winner's ack = 1. Go to IDLE unconditionally, so a requester that still holds req during its ack cycle is never re-granted on it.
- memAddr/memWData output the latched registers and stay stable from SETUP through DONE.
- RData registers change only on a read by their own port. Writes and the other port's reads leave them unchanged.
- A req dropped mid-access is a protocol violation. The access still completes and ack still pulses.
- The arbiter does not mask addresses; all 16 bits pass through.

## Timing
- Reset (edge with reset = 1): state IDLE; memNotCS/memNotOE/memNotWE = 1; memDataOE = 0; cpuAck = dmaAck = 0; cpuRData = dmaRData = 0; memAddr = memWData = 0; cnt = 0; grant = 0; lastGrant = 1, so the CPU wins the first contention. Reset mid-access aborts it: strobes high after that edge, no ack.
- Latency: req sampled high in IDLE at edge 0 → SETUP after edge 0, ACCESS after edge 1, DONE after edge 1+WAIT_CYCLES → ack high for the cycle after edge 1+WAIT_CYCLES. RData is valid in the same cycle as ack.
- Throughput: one access per WAIT_CYCLES+3 cycles. Under continuous contention, grants alternate CPU, DMA, CPU, ...
- Requester may drop req on the edge ending its ack cycle. If it instead keeps req high into IDLE, that counts as a new request.
- All outputs are registered from state/latched registers (no combinational path from req to strobes).

## Test plan
- Reset: hold reset 2 cycles mid-ACCESS of a write → next cycle memNotWE = memNotCS = 1, memDataOE = 0, no ack, cpuRData = 0, busy = 0.
- CPU write then read, WAIT_CYCLES = 1: write 0xBEEF to 0x0010 → memNotWE low exactly 1 cycle, cpuAck 3 cycles after req; read 0x0010 → cpuRData = 0xBEEF with cpuAck.
- WAIT_CYCLES = 3 DMA read of preloaded 0x1234 at 0xFFFF → memNotOE low 4 cycles (SETUP+3), dmaAck at cycle 5, dmaRData = 0x1234, cpuRData unchanged.
- Contention: both req high from reset, both held, WAIT_CYCLES = 1 → acks in order CPU, DMA, CPU, DMA, each 4 cycles apart, grant toggling.
- Back-to-back single requester: CPU keeps req high across ack with new address → second access starts, never two acks for one request, DMA request raised mid-access served next.
- Write data hold: during a write, memWData/memAddr stable and memDataOE = 1 from SETUP through DONE, and memNotWE high in both SETUP and DONE.
